// File: rtl/mips_cpu_pkg.sv
// Shared MIPS bus CPU types: load-type encoding (decoder, request block, readback)
// and the bus readback state machine states.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LB  = 3'd1,
        LT_LBU = 3'd2,
        LT_LH  = 3'd3,
        LT_LHU = 3'd4,
        LT_LWL = 3'd5,
        LT_LWR = 3'd6
    } load_type_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } rb_state_t;

endpackage

// File: rtl/mips_cpu_bus_readback_if.sv
// Memory bus signals seen by the readback stage: request strobes from the
// request block, plus the memory's waitrequest/readdata responses.
interface mips_cpu_bus_readback_if;
    logic        read;
    logic        write;
    logic        fetch;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (output read, write, fetch, input waitrequest, readdata);
    modport slave  (input read, write, fetch, waitrequest, readdata);
endinterface

// File: rtl/mips_cpu_bus_load_align.sv
// Combinational load alignment: lane select, sign/zero extension and
// LWL/LWR merge of a little-endian memory word into a register value.
module mips_cpu_bus_load_align
    import mips_cpu_pkg::*;
(
    input  logic [31:0] readdata,
    input  load_type_t  load_type,
    input  logic [1:0]  addr_offset,
    input  logic [31:0] rt_old,
    output logic [31:0] aligned
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [4:0]  shl;
    logic [4:0]  shr;
    logic [31:0] mask_keep_low;
    logic [31:0] mask_keep_high;

    assign byte_sel       = readdata[{addr_offset, 3'b000} +: 8];
    assign half_sel       = readdata[{addr_offset[1], 4'b0000} +: 16];
    assign shl            = {2'd3 - addr_offset, 3'b000};
    assign shr            = {addr_offset, 3'b000};
    // LWL keeps the rt bytes below the shifted word, LWR keeps those above it
    assign mask_keep_low  = (32'h1 << shl) - 32'd1;
    assign mask_keep_high = ~(32'hFFFF_FFFF >> shr);

    always_comb begin
        aligned = readdata;
        case (load_type)
            LT_LB:   aligned = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  aligned = {24'd0, byte_sel};
            LT_LH:   aligned = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  aligned = {16'd0, half_sel};
            LT_LWL:  aligned = (readdata << shl) | (rt_old & mask_keep_low);
            LT_LWR:  aligned = (readdata >> shr) | (rt_old & mask_keep_high);
            default: aligned = readdata;
        endcase
    end
endmodule

// File: rtl/mips_cpu_bus_readback.sv
// Bus response stage: tracks bus accesses through waitrequest, stalls the CPU,
// captures fetches/loads. Optional bus timeout under MIPS_CPU_BUS_TIMEOUT_EN.
module mips_cpu_bus_readback
    import mips_cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    mips_cpu_bus_readback_if.slave         bus,
    input  load_type_t                     load_type,
    input  logic [1:0]                     addr_offset,
    input  logic [31:0]                    rt_old,
    output logic                           stall,
    output logic [31:0]                    instr,
    output logic [31:0]                    load_data,
    output logic                           load_valid,
    output logic                           bus_error
);
    rb_state_t   state_reg, state_next;
    logic [31:0] instr_reg;
    logic [31:0] load_data_reg;
    logic        load_valid_reg;
    logic        bus_error_reg;
    logic        timeout_hit;
    logic        req;
    logic        complete;
    logic [31:0] aligned;

    assign req = bus.read | bus.write;

    mips_cpu_bus_load_align u_align (
        .readdata    (bus.readdata),
        .load_type   (load_type),
        .addr_offset (addr_offset),
        .rt_old      (rt_old),
        .aligned     (aligned)
    );

`ifdef MIPS_CPU_BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Counts stall cycles of the current access; the accepting cycle is the first
    logic [CNT_W-1:0] wait_cnt_reg;

    assign timeout_hit = (state_reg == ST_WAIT) && req && bus.waitrequest
                         && (wait_cnt_reg >= CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_reg  <= '0;
            bus_error_reg <= 1'b0;
        end else begin
            wait_cnt_reg <= (state_next == ST_WAIT) ? wait_cnt_reg + 1'b1 : '0;
            if (timeout_hit)
                bus_error_reg <= 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg    = (TIMEOUT_CYCLES == 0);
    assign timeout_hit   = 1'b0;
    assign bus_error_reg = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        complete   = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                state_next = ST_IDLE;
                if (req && !bus_error_reg) begin
                    if (bus.waitrequest) begin
                        state_next = ST_WAIT;
                    end else begin
                        complete   = 1'b1;
                        state_next = bus.read ? ST_DONE : ST_IDLE;
                    end
                end
            end
            ST_WAIT: begin
                // Strobe dropped mid-access: abandon without capture
                if (!req) begin
                    state_next = ST_IDLE;
                end else if (!bus.waitrequest) begin
                    complete   = 1'b1;
                    state_next = bus.read ? ST_DONE : ST_IDLE;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            instr_reg      <= '0;
            load_data_reg  <= '0;
            load_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            load_valid_reg <= complete && bus.read && !bus.fetch;
            if (complete && bus.read) begin
                if (bus.fetch)
                    instr_reg <= bus.readdata;
                else
                    load_data_reg <= aligned;
            end
        end
    end

    assign stall      = req & bus.waitrequest & ~bus_error_reg;
    assign instr      = instr_reg;
    assign load_data  = load_data_reg;
    assign load_valid = load_valid_reg;
    assign bus_error  = bus_error_reg;
endmodule

// File: tb/tb_mips_cpu_bus_readback.sv
// Directed bench for mips_cpu_bus_readback; the timeout steps run only when
// MIPS_CPU_BUS_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=4).
module tb_mips_cpu_bus_readback;
    import mips_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    load_type_t  load_type;
    logic [1:0]  addr_offset;
    logic [31:0] rt_old;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] load_data;
    logic        load_valid;
    logic        bus_error;

    int checks   = 0;
    int failures = 0;

    mips_cpu_bus_readback_if bus ();

    mips_cpu_bus_readback #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .load_type   (load_type),
        .addr_offset (addr_offset),
        .rt_old      (rt_old),
        .stall       (stall),
        .instr       (instr),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .bus_error   (bus_error)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Zero-wait load: strobe one cycle, expect load_valid/load_data the next
    task automatic do_load(input string tag, input load_type_t lt, input logic [1:0] k,
                           input logic [31:0] rd, input logic [31:0] rt,
                           input logic [31:0] exp);
        cyc();
        bus.read = 1'b1; bus.write = 1'b0; bus.fetch = 1'b0; bus.waitrequest = 1'b0;
        bus.readdata = rd; load_type = lt; addr_offset = k; rt_old = rt;
        #1;
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        cyc();
        bus.read = 1'b0;
        #1;
        chk({tag, "_valid"}, 32'(load_valid), 32'd1);
        chk({tag, "_data"}, load_data, exp);
        $display("load %s rd=%h k=%0d rt=%h -> %h", tag, rd, k, rt, load_data);
        cyc();
        chk({tag, "_valid_end"}, 32'(load_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.read = 1'b0; bus.write = 1'b0; bus.fetch = 1'b0;
        bus.waitrequest = 1'b0; bus.readdata = '0;
        load_type = LT_LW; addr_offset = 2'd0; rt_old = '0;
        cyc(); cyc();
        reset = 1'b0;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_load_valid", 32'(load_valid), 32'd0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);

        // Fetch with 3 wait cycles
        cyc();
        bus.read = 1'b1; bus.fetch = 1'b1; bus.waitrequest = 1'b1; bus.readdata = 32'h8C41_0004;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("fetch_stall%0d", i), 32'(stall), 32'd1);
            if (i < 2) cyc();
        end
        cyc();
        bus.waitrequest = 1'b0;
        #1;
        chk("fetch_stall_done", 32'(stall), 32'd0);
        cyc();
        bus.read = 1'b0; bus.fetch = 1'b0;
        #1;
        chk("fetch_instr", instr, 32'h8C41_0004);
        chk("fetch_no_valid", 32'(load_valid), 32'd0);
        chk("fetch_load_data", load_data, 32'd0);
        $display("fetch rd=8c410004 -> instr=%h", instr);

        do_load("lb_k2",  LT_LB,  2'd2, 32'h1280_5678, 32'h0, 32'hFFFF_FF80);
        do_load("lbu_k2", LT_LBU, 2'd2, 32'h1280_5678, 32'h0, 32'h0000_0080);
        do_load("lb_k0",  LT_LB,  2'd0, 32'h1280_5678, 32'h0, 32'h0000_0078);
        do_load("lhu_k2", LT_LHU, 2'd2, 32'h8001_1234, 32'h0, 32'h0000_8001);
        do_load("lh_k2",  LT_LH,  2'd2, 32'h8001_1234, 32'h0, 32'hFFFF_8001);
        do_load("lh_k0",  LT_LH,  2'd0, 32'h8001_9234, 32'h0, 32'hFFFF_9234);
        do_load("lwl_k1", LT_LWL, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'hCCDD_3344);
        do_load("lwr_k1", LT_LWR, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h11AA_BBCC);
        do_load("lwl_k3", LT_LWL, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CCDD);
        do_load("lwr_k0", LT_LWR, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CCDD);
        do_load("lwl_k0", LT_LWL, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 32'hDD22_3344);
        do_load("lwr_k3", LT_LWR, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_33AA);
        do_load("lw_k0",  LT_LW,  2'd0, 32'h0BAD_F00D, 32'h0, 32'h0BAD_F00D);

        // Back-to-back loads: second request accepted in DONE
        cyc();
        bus.read = 1'b1; bus.waitrequest = 1'b0; bus.readdata = 32'h0000_00F1;
        load_type = LT_LBU; addr_offset = 2'd0;
        cyc();
        bus.readdata = 32'hDEAD_BEEF; load_type = LT_LW;
        #1;
        chk("b2b_valid1", 32'(load_valid), 32'd1);
        chk("b2b_data1", load_data, 32'h0000_00F1);
        cyc();
        bus.read = 1'b0;
        #1;
        chk("b2b_valid2", 32'(load_valid), 32'd1);
        chk("b2b_data2", load_data, 32'hDEAD_BEEF);
        $display("b2b loads -> %h", load_data);

        // Strobe dropped while waiting: nothing captured
        cyc();
        bus.read = 1'b1; bus.waitrequest = 1'b1; bus.readdata = 32'h5555_5555;
        cyc();
        bus.read = 1'b0;
        #1;
        chk("drop_stall", 32'(stall), 32'd0);
        cyc();
        bus.waitrequest = 1'b0;
        #1;
        chk("drop_no_valid", 32'(load_valid), 32'd0);
        chk("drop_state", 32'(dut.state_reg), 32'(ST_IDLE));
        chk("drop_data_kept", load_data, 32'hDEAD_BEEF);
        $display("dropped strobe -> load_data=%h", load_data);

        // Write held in WAIT, reset on second wait cycle
        cyc();
        bus.write = 1'b1; bus.waitrequest = 1'b1;
        #1;
        chk("wr_stall0", 32'(stall), 32'd1);
        cyc();
        reset = 1'b1;
        #1;
        chk("wr_stall1", 32'(stall), 32'd1);
        cyc();
        reset = 1'b0; bus.write = 1'b0; bus.waitrequest = 1'b0;
        #1;
        chk("wrrst_state", 32'(dut.state_reg), 32'(ST_IDLE));
        chk("wrrst_instr", instr, 32'd0);
        chk("wrrst_load_data", load_data, 32'd0);
        chk("wrrst_load_valid", 32'(load_valid), 32'd0);
        chk("wrrst_bus_error", 32'(bus_error), 32'd0);
        $display("write reset mid-wait -> instr=%h load_data=%h", instr, load_data);

`ifdef MIPS_CPU_BUS_TIMEOUT_EN
        // Stuck waitrequest: bus_error after 4 stall cycles
        cyc();
        bus.read = 1'b1; bus.waitrequest = 1'b1; bus.readdata = 32'h1234_5678; load_type = LT_LW;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_stall%0d", i), 32'(stall), 32'd1);
            chk($sformatf("to_err_low%0d", i), 32'(bus_error), 32'd0);
            cyc();
        end
        chk("to_bus_error", 32'(bus_error), 32'd1);
        chk("to_stall_low", 32'(stall), 32'd0);
        bus.waitrequest = 1'b0;
        cyc();
        chk("to_ignored_valid", 32'(load_valid), 32'd0);
        chk("to_ignored_data", load_data, 32'd0);
        chk("to_err_sticky", 32'(bus_error), 32'd1);
        bus.read = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("to_err_cleared", 32'(bus_error), 32'd0);
        $display("timeout -> bus_error cleared by reset");
`else
        // No timeout: WAIT persists indefinitely
        cyc();
        bus.read = 1'b1; bus.fetch = 1'b1; bus.waitrequest = 1'b1; bus.readdata = 32'h2402_0007;
        for (int i = 0; i < 10; i++) cyc();
        chk("nto_stall", 32'(stall), 32'd1);
        chk("nto_bus_error", 32'(bus_error), 32'd0);
        bus.waitrequest = 1'b0;
        cyc();
        bus.read = 1'b0; bus.fetch = 1'b0;
        #1;
        chk("nto_instr", instr, 32'h2402_0007);
        $display("long wait fetch -> instr=%h", instr);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mips_cpu_bus_readback.md
# mips_cpu_bus_readback

Bus response stage of the MIPS bus CPU, directly downstream of the bus request block. Tracks each read/write issued on the memory bus through `waitrequest` stalls and stalls the CPU state machine until the access completes. Captures `readdata`: instruction fetches go to the instruction register; loads are lane-aligned, sign/zero-extended or merged (LWL/LWR) into a register write-back value.

## Interface
- `TIMEOUT_CYCLES`, 255: stall cycles before a bus error is raised (used only with `BUS_TIMEOUT_EN`).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `read` in 1: bus read strobe from the request block.
- `write` in 1: bus write strobe from the request block.
- `fetch` in 1: current read is an instruction fetch.
- `waitrequest` in 1: memory not ready.
- `readdata` in 32: memory read word, lane-ordered little-endian.
- `load_type` in 3: 0=LW, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LWL, 6=LWR; 7 treated as LW.
- `addr_offset` in 2: effective-address bits [1:0] of the load.
- `rt_old` in 32: current rt value for LWL/LWR merge.
- `stall` out 1: hold CPU state; combinational.
- `instr` out 32: instruction register.
- `load_data` out 32: aligned load result.
- `load_valid` out 1: one-cycle pulse, `load_data` valid.
- `bus_error` out 1: sticky timeout flag.

## Operation
- States: IDLE, WAIT, DONE.
- A request is present when `read | write` is high. Accepted in IDLE or DONE.
  - With `waitrequest`=1 → WAIT.
  - With `waitrequest`=0 → access completes this cycle; → DONE if read, else IDLE.
- WAIT:
  - Completes on the first cycle with `waitrequest`=0; → DONE for a read, IDLE for a write.
  - Strobe dropping while in WAIT is a protocol violation: return to IDLE and capture nothing.
- Capture at completion edge of a read:
  - `fetch`=1: `instr` ← `readdata`; `load_data` unchanged.
  - `fetch`=0: `load_data` ← aligned value; `load_valid` high throughout DONE.
- Alignment, k = `addr_offset`, b = byte k, h = halfword k[1]:
  - LB = sext(b).
  - LBU = zext(b).
  - LH = sext(h).
  - LHU = zext(h).
  - LW = `readdata`.
  - LWL = (`readdata` << 8·(3−k)) | (`rt_old` & (2^(8·(3−k))−1)).
  - LWR = (`readdata` >> 8k) | (`rt_old` & ~(0xFFFFFFFF >> 8k)).
  - All widths 32 bits. Shift amounts are 0–24. LWL at k=3 and LWR at k=0 equal LW.
- `stall` = (`read` | `write`) & `waitrequest` & ~`bus_error`.

## Timing
- Reset values: state IDLE; `instr`, `load_data` = 0; `load_valid`, `bus_error` = 0. `stall` follows its equation.
- Zero-wait read: strobe in cycle N, `load_valid` in cycle N+1.
- W wait cycles: `stall` high for cycles N..N+W−1; `load_valid` in cycle N+W+1.
- DONE lasts one cycle. A request in DONE is accepted as in IDLE, giving back-to-back accesses with no bubble.
- `reset` in any state overrides all else on that edge. No capture occurs, and `bus_error` clears.

## Configuration
- `MIPS_CPU_BUS_TIMEOUT_EN` defined:
  - A counter of up to 8 bits, sized from `TIMEOUT_CYCLES`, counts consecutive WAIT cycles.
  - On reaching `TIMEOUT_CYCLES`: set `bus_error`, force `stall` low, → IDLE, capture nothing.
  - `bus_error` holds until `reset`. While it is set, new requests are ignored.
- Not defined: no counter; `bus_error` tied 0; WAIT lasts indefinitely.

## Structure
- Shared package `mips_cpu_pkg` holds:
  - the `load_type` encoding as a typedef enum, shared with the decoder and the request block;
  - the readback state enum.
- One combinational sub-module, `mips_cpu_bus_load_align`, takes (`readdata`, `load_type`, `addr_offset`, `rt_old`) → aligned word. The FSM and registers stay in the top.

## Test plan
- Fetch, `waitrequest` high for 3 cycles, `readdata`=0x8C410004 → `stall` high 3 cycles; `instr`=0x8C410004 next cycle; `load_valid` stays 0.
- LB, k=2, `readdata`=0x12805678 → `load_data`=0xFFFFFF80. Same with LBU → 0x00000080.
- LHU, k=2, `readdata`=0x80011234 → 0x00008001. Same with LH → 0xFFFF8001.
- LWL, k=1, `readdata`=0xAABBCCDD, `rt_old`=0x11223344 → 0xCCDD3344. LWR, k=1, same inputs → 0x11AABBCC.
- Write held in WAIT, `reset` on the 2nd wait cycle → state IDLE, all outputs at reset values, no `load_valid`.
- With macro, `TIMEOUT_CYCLES`=4, `waitrequest` stuck high → `bus_error` set after 4 wait cycles, `stall` low; following requests ignored until `reset`.
